// File: rtl/ram_slot_scheduler.sv
// ram_slot_scheduler: time-division arbiter for the shared 8 MHz RAM bus.
// A free-running 2-bit phase (busCycle) selects per-slot priority among
// video fetch, CPU and sound buffer fetch. Every output is registered and
// changes only on a clk_en edge, or on any clk edge while reset is high.
module ram_slot_scheduler #(
  parameter logic [21:0] kSndBase = 22'h3FFD00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  output logic [1:0]  busCycle,
  input  logic        loadPixels,
  input  logic [21:0] videoAddr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  output logic        cpu_ack,
  input  logic        snd_req,
  input  logic [7:0]  snd_addr,
  output logic        snd_ack,
  output logic [7:0]  snd_overrun,
  output logic [1:0]  owner,
  output logic [21:0] ram_addr,
  output logic        ram_oe,
  output logic        ram_we
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_SND  = 2'd3
  } owner_e;

  logic [1:0]  bus_cycle_q;
  owner_e      owner_q;
  owner_e      grant_d;
  logic [21:0] ram_addr_q;
  logic        ram_oe_q;
  logic        ram_we_q;
  logic        cpu_ack_q;
  logic        snd_ack_q;
  logic        snd_pend_q;
  logic [7:0]  snd_ovr_q;
  logic [21:0] snd_full_addr;

  // The offset wraps modulo 2^22 through the natural adder width.
  assign snd_full_addr = kSndBase + {14'd0, snd_addr};

  // Per-phase priority. Arbitration looks only at the registered pending
  // flag, so a sound request needs one edge to be latched before it can win.
  always_comb begin
    grant_d = OWN_IDLE;
    case (bus_cycle_q)
      2'd0: begin
        if (loadPixels)   grant_d = OWN_VID;
        else if (snd_pend_q) grant_d = OWN_SND;
        else if (cpu_req) grant_d = OWN_CPU;
      end
      2'd2: begin
        if (snd_pend_q)   grant_d = OWN_SND;
        else if (cpu_req) grant_d = OWN_CPU;
      end
      default: begin
        if (cpu_req)      grant_d = OWN_CPU;
        else if (snd_pend_q) grant_d = OWN_SND;
      end
    endcase
  end

  // Phase counter, grant registers, RAM strobes and sound request bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_cycle_q <= 2'd0;
      owner_q     <= OWN_IDLE;
      ram_addr_q  <= 22'd0;
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      snd_ack_q   <= 1'b0;
      snd_pend_q  <= 1'b0;
      snd_ovr_q   <= 8'd0;
    end else if (clk_en) begin
      bus_cycle_q <= bus_cycle_q + 2'd1;
      owner_q     <= grant_d;
      cpu_ack_q   <= (grant_d == OWN_CPU);
      snd_ack_q   <= (grant_d == OWN_SND);
      case (grant_d)
        OWN_VID: begin
          ram_addr_q <= videoAddr;
          ram_oe_q   <= 1'b1;
          ram_we_q   <= 1'b0;
        end
        OWN_CPU: begin
          ram_addr_q <= cpu_addr;
          ram_oe_q   <= ~cpu_we;
          ram_we_q   <= cpu_we;
        end
        OWN_SND: begin
          ram_addr_q <= snd_full_addr;
          ram_oe_q   <= 1'b1;
          ram_we_q   <= 1'b0;
        end
        default: begin
          // Idle slot: strobes drop, address is left where it was.
          ram_oe_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
      // A request arriving on the serving edge re-arms the flag; one arriving
      // while an unserved request is still pending is lost and counted.
      if (grant_d == OWN_SND) begin
        snd_pend_q <= snd_req;
      end else if (snd_req) begin
        snd_pend_q <= 1'b1;
        if (snd_pend_q && (snd_ovr_q != 8'hFF)) snd_ovr_q <= snd_ovr_q + 8'd1;
      end
    end
  end

  assign busCycle    = bus_cycle_q;
  assign owner       = owner_q;
  assign ram_addr    = ram_addr_q;
  assign ram_oe      = ram_oe_q;
  assign ram_we      = ram_we_q;
  assign cpu_ack     = cpu_ack_q;
  assign snd_ack     = snd_ack_q;
  assign snd_overrun = snd_ovr_q;

endmodule

// File: tb/tb_ram_slot_scheduler.sv
// Scoreboard bench for ram_slot_scheduler: every clock step pushes the
// hand-computed output state expected after that edge; a monitor pops and
// compares one entry per clock edge.
module tb_ram_slot_scheduler;

  typedef struct packed {
    logic [1:0]  bc;
    logic [1:0]  own;
    logic [21:0] addr;
    logic        oe;
    logic        we;
    logic        cack;
    logic        sack;
    logic [7:0]  ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic [1:0]  busCycle;
  logic        loadPixels = 1'b0;
  logic [21:0] videoAddr = 22'd0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [21:0] cpu_addr = 22'd0;
  logic        cpu_ack;
  logic        snd_req = 1'b0;
  logic [7:0]  snd_addr = 8'd0;
  logic        snd_ack;
  logic [7:0]  snd_overrun;
  logic [1:0]  owner;
  logic [21:0] ram_addr;
  logic        ram_oe;
  logic        ram_we;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  ram_slot_scheduler #(.kSndBase(22'h3FFD00)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .busCycle(busCycle),
    .loadPixels(loadPixels), .videoAddr(videoAddr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .snd_req(snd_req), .snd_addr(snd_addr), .snd_ack(snd_ack),
    .snd_overrun(snd_overrun), .owner(owner), .ram_addr(ram_addr),
    .ram_oe(ram_oe), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] bc, input logic [1:0] own,
                              input logic [21:0] addr, input logic oe,
                              input logic we, input logic ca, input logic sa,
                              input logic [7:0] ov);
    exp_t e;
    e.bc = bc; e.own = own; e.addr = addr; e.oe = oe; e.we = we;
    e.cack = ca; e.sack = sa; e.ovr = ov;
    return e;
  endfunction

  // Monitor: one comparison per clock edge that has an expectation queued.
  always @(posedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      exp_t a;
      #1;
      e = sb_q.pop_front();
      a = mk(busCycle, owner, ram_addr, ram_oe, ram_we, cpu_ack, snd_ack, snd_overrun);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d: got bc=%0d own=%0d addr=%h oe=%b we=%b cack=%b sack=%b ovr=%0d, want bc=%0d own=%0d addr=%h oe=%b we=%b cack=%b sack=%b ovr=%0d",
                 checks, a.bc, a.own, a.addr, a.oe, a.we, a.cack, a.sack, a.ovr,
                 e.bc, e.own, e.addr, e.oe, e.we, e.cack, e.sack, e.ovr);
      end
    end
  end

  // One clock step: drive clk_en, queue the expected post-edge state.
  task automatic cyc(input logic en, input exp_t e);
    @(negedge clk);
    clk_en = en;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  localparam logic [21:0] CA = 22'h000ABC;
  localparam logic [21:0] CW = 22'h001234;

  initial begin
    // Reset state
    cyc(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // 8 clk_en pulses with no requests; outputs hold while clk_en is low
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, mk(2'((i + 1) % 4), 0, 0, 0, 0, 0, 0, 0));
      cyc(1'b0, mk(2'((i + 1) % 4), 0, 0, 0, 0, 0, 0, 0));
    end

    // CPU write with no competitors, then idle slots hold the address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = CW;
    cyc(1'b1, mk(1, 2, CW, 0, 1, 1, 0, 0));
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc(1'b1, mk(2, 0, CW, 0, 0, 0, 0, 0));
    cyc(1'b1, mk(3, 0, CW, 0, 0, 0, 0, 0));
    cyc(1'b1, mk(0, 0, CW, 0, 0, 0, 0, 0));

    // Video on slot 0, CPU on 1..3
    cpu_req = 1'b1; cpu_addr = CA; loadPixels = 1'b1; videoAddr = 22'h100200;
    cyc(1'b1, mk(1, 1, 22'h100200, 1, 0, 0, 0, 0));
    cyc(1'b1, mk(2, 2, CA, 1, 0, 1, 0, 0));
    cyc(1'b1, mk(3, 2, CA, 1, 0, 1, 0, 0));
    videoAddr = 22'h100240;
    cyc(1'b1, mk(0, 2, CA, 1, 0, 1, 0, 0));
    cyc(1'b1, mk(1, 1, 22'h100240, 1, 0, 0, 0, 0));
    cyc(1'b1, mk(2, 2, CA, 1, 0, 1, 0, 0));
    cyc(1'b1, mk(3, 2, CA, 1, 0, 1, 0, 0));
    cyc(1'b1, mk(0, 2, CA, 1, 0, 1, 0, 0));
    loadPixels = 1'b0;

    // Sound pulse at slot 0 with CPU busy: served on the slot 2 decision
    snd_req = 1'b1; snd_addr = 8'h10;
    cyc(1'b1, mk(1, 2, CA, 1, 0, 1, 0, 0));
    snd_req = 1'b0;
    cyc(1'b1, mk(2, 2, CA, 1, 0, 1, 0, 0));
    cyc(1'b1, mk(3, 3, 22'h3FFD10, 1, 0, 0, 1, 0));
    cyc(1'b1, mk(0, 2, CA, 1, 0, 1, 0, 0));

    // Request on the serving edge re-arms pending without overrun
    snd_req = 1'b1; snd_addr = 8'h30;
    cyc(1'b1, mk(1, 2, CA, 1, 0, 1, 0, 0));
    snd_req = 1'b0;
    cyc(1'b1, mk(2, 2, CA, 1, 0, 1, 0, 0));
    snd_req = 1'b1;
    cyc(1'b1, mk(3, 3, 22'h3FFD30, 1, 0, 0, 1, 0));
    snd_req = 1'b0;
    cyc(1'b1, mk(0, 2, CA, 1, 0, 1, 0, 0));
    cpu_req = 1'b0;
    cyc(1'b1, mk(1, 3, 22'h3FFD30, 1, 0, 0, 1, 0));
    cyc(1'b1, mk(2, 0, 22'h3FFD30, 0, 0, 0, 0, 0));
    cyc(1'b1, mk(3, 0, 22'h3FFD30, 0, 0, 0, 0, 0));
    cyc(1'b1, mk(0, 0, 22'h3FFD30, 0, 0, 0, 0, 0));

    // Back-to-back sound pulses while CPU holds slots 1/3: overrun counts
    // one per pair and saturates at 255
    cpu_req = 1'b1; snd_addr = 8'h20;
    for (int i = 0; i < 301; i++) begin
      snd_req = 1'b1;
      cyc(1'b1, mk(1, 2, CA, 1, 0, 1, 0, 8'((i > 255) ? 255 : i)));
      cyc(1'b1, mk(2, 2, CA, 1, 0, 1, 0, 8'((i + 1 > 255) ? 255 : i + 1)));
      snd_req = 1'b0;
      cyc(1'b1, mk(3, 3, 22'h3FFD20, 1, 0, 0, 1, 8'((i + 1 > 255) ? 255 : i + 1)));
      cyc(1'b1, mk(0, 2, CA, 1, 0, 1, 0, 8'((i + 1 > 255) ? 255 : i + 1)));
    end

    // Reset during a CPU grant with clk_en low, then re-grant
    cyc(1'b0, mk(0, 2, CA, 1, 0, 1, 0, 255));
    reset = 1'b1;
    cyc(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    cyc(1'b1, mk(1, 2, CA, 1, 0, 1, 0, 0));
    cpu_req = 1'b0;
    cyc(1'b1, mk(2, 0, CA, 0, 0, 0, 0, 0));
    cyc(1'b0, mk(2, 0, CA, 0, 0, 0, 0, 0));

    // Drain scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
